// File: rtl/deser_pkg.sv
// rtl/deser_pkg.sv - shared state encoding, default COM value and counter width helper
package deser_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [7:0] K28_5 = 8'hBC;

  // Width able to hold values 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/deser_shift_reg.sv
// rtl/deser_shift_reg.sv - serial shift register presenting the symbol completed at each edge
module deser_shift_reg
  import deser_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_L,
  input  logic             data_in,
  output logic [WIDTH-1:0] window,
  output logic             primed
);

  localparam int FW = cnt_width(WIDTH);

  // Only WIDTH-1 history bits are needed; the newest bit comes straight from data_in.
  logic [WIDTH-2:0] sreg;
  logic [FW-1:0]    fill_cnt;

  assign window = {sreg, data_in};
  assign primed = (fill_cnt == FW'(WIDTH - 1));

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      sreg     <= '0;
      fill_cnt <= '0;
    end else begin
      sreg <= window[WIDTH-2:0];
      if (!primed) fill_cnt <= fill_cnt + FW'(1);
    end
  end

endmodule

// File: rtl/serial_paralelo_align.sv
// rtl/serial_paralelo_align.sv - COM-aligned serial-to-parallel receiver; DESER_COM_PASS_EN passes COM symbols via com_out
module serial_paralelo_align
  import deser_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] COM      = WIDTH'(K28_5),
  parameter int               COM_LOCK = 2,
  parameter int               MAX_GAP  = 16
) (
  input  logic             clock,
  input  logic             reset_L,
  input  logic             data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
`ifdef DESER_COM_PASS_EN
  output logic             com_out,
`endif
  output logic             lock_out
);

  localparam int BW = cnt_width(WIDTH);
  localparam int CW = cnt_width(COM_LOCK + 1);
  localparam int GW = cnt_width(MAX_GAP);

  state_t           state, next_state;
  logic [BW-1:0]    bit_cnt;
  logic [CW-1:0]    com_cnt;
  logic [GW-1:0]    gap_cnt;
  logic [WIDTH-1:0] window;
  logic             primed;
  logic             boundary, win_com, gap_last;
  logic             emit_data;
`ifdef DESER_COM_PASS_EN
  logic             emit_com;
`endif

  deser_shift_reg #(.WIDTH(WIDTH)) u_shift (
    .clock   (clock),
    .reset_L (reset_L),
    .data_in (data_in),
    .window  (window),
    .primed  (primed)
  );

  assign boundary = (bit_cnt == BW'(WIDTH - 1));
  assign win_com  = (window == COM);
  assign gap_last = (gap_cnt == GW'(MAX_GAP - 1));

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) state <= HUNT;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      HUNT:    if (primed && win_com) next_state = (COM_LOCK == 1) ? LOCKED : CHECK;
      CHECK:   if (boundary) begin
                 if (!win_com) next_state = HUNT;
                 else if (com_cnt == CW'(COM_LOCK - 1)) next_state = LOCKED;
               end
      LOCKED:  if (boundary && !win_com && gap_last) next_state = HUNT;
      default: next_state = HUNT;
    endcase
  end

  always_comb begin
    lock_out  = (state == LOCKED);
    emit_data = (state == LOCKED) && boundary && !win_com && !gap_last;
`ifdef DESER_COM_PASS_EN
    emit_com  = (state == LOCKED) && boundary && win_com;
`endif
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      bit_cnt <= '0;
      com_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      case (state)
        HUNT: if (primed && win_com) begin
          bit_cnt <= '0;
          com_cnt <= CW'(1);
          gap_cnt <= '0;
        end
        CHECK: begin
          bit_cnt <= boundary ? '0 : bit_cnt + BW'(1);
          if (boundary) com_cnt <= win_com ? com_cnt + CW'(1) : '0;
        end
        LOCKED: begin
          bit_cnt <= boundary ? '0 : bit_cnt + BW'(1);
          if (boundary) begin
            if (win_com || gap_last) gap_cnt <= '0;
            else                     gap_cnt <= gap_cnt + GW'(1);
            if (!win_com && gap_last) com_cnt <= '0;
          end
        end
        default: begin
          bit_cnt <= '0;
          com_cnt <= '0;
          gap_cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      data_out  <= '0;
      valid_out <= 1'b0;
`ifdef DESER_COM_PASS_EN
      com_out   <= 1'b0;
`endif
    end else begin
`ifdef DESER_COM_PASS_EN
      valid_out <= emit_data | emit_com;
      com_out   <= emit_com;
      if (emit_data || emit_com) data_out <= window;
`else
      valid_out <= emit_data;
      if (emit_data) data_out <= window;
`endif
    end
  end

endmodule
